rob_commit: RTL

- 16-entry reorder buffer that sits directly downstream of the branch unit and the ALU writeback paths.
- Allocates entries in program order at dispatch and records completion results tagged by ROB index.
- Retires entries in order from the head.
- On a taken branch reaching the head, flushes all younger work and redirects fetch. The front end always predicts not-taken.

---
 rtl/rob_commit_pkg.sv | 19 +
 rtl/rob_commit_if.sv | 49 ++++
 rtl/rob_commit_ptr.sv | 34 +++
 rtl/rob_commit.sv | 109 ++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// Shared constants for the reorder buffer, decode and branch unit.
package rob_commit_pkg;

  localparam int ROB_ENTRIES = 16;
  localparam int ROB_IDX_W   = 4;
  localparam int DATA_W      = 16;
  localparam int REG_W       = 4;

  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_JNZ = 4'b1001;
  localparam logic [3:0] OP_JGT = 4'b1010;
  localparam logic [3:0] OP_JLT = 4'b1011;

  // All conditional branches share the 10xx opcode space.
  function automatic logic is_branch_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/rob_commit_if.sv
// Dispatch, writeback, commit and redirect signals of the reorder buffer.
interface rob_commit_if import rob_commit_pkg::*; #(
  parameter int IDX_W  = ROB_IDX_W,
  parameter int DATA_W = rob_commit_pkg::DATA_W
);

  logic              alloc_valid;
  logic              alloc_is_branch;
  logic [REG_W-1:0]  alloc_dest;
  logic              alloc_wr;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_index;

  logic              alu_valid;
  logic [IDX_W-1:0]  alu_index;
  logic [DATA_W-1:0] alu_value;

  logic              br_valid;
  logic [IDX_W-1:0]  br_index;
  logic [DATA_W-1:0] br_target;
  logic              br_taken;

  logic              commit_valid;
  logic              commit_wr;
  logic [REG_W-1:0]  commit_dest;
  logic [DATA_W-1:0] commit_value;
  logic              flush;
  logic [DATA_W-1:0] flush_pc;
  logic [IDX_W:0]    count;

  modport master (
    output alloc_valid, alloc_is_branch, alloc_dest, alloc_wr,
    input  alloc_ready, alloc_index,
    output alu_valid, alu_index, alu_value,
    output br_valid, br_index, br_target, br_taken,
    input  commit_valid, commit_wr, commit_dest, commit_value,
    input  flush, flush_pc, count
  );

  modport slave (
    input  alloc_valid, alloc_is_branch, alloc_dest, alloc_wr,
    output alloc_ready, alloc_index,
    input  alu_valid, alu_index, alu_value,
    input  br_valid, br_index, br_target, br_taken,
    output commit_valid, commit_wr, commit_dest, commit_value,
    output flush, flush_pc, count
  );

endinterface

// File: rtl/rob_commit_ptr.sv
// Head/tail/occupancy bookkeeping for the reorder buffer, with wrap and full/empty.
module rob_commit_ptr import rob_commit_pkg::*; #(
  parameter int ENTRIES = ROB_ENTRIES,
  parameter int IDX_W   = ROB_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_fire,
  input  logic             commit_fire,
  input  logic             flush,
  output logic [IDX_W-1:0] head,
  output logic [IDX_W-1:0] tail,
  output logic [IDX_W:0]   count,
  output logic             full,
  output logic             empty
);

  // Pointers wrap naturally because ENTRIES is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire)  tail <= tail + 1'b1;
      if (commit_fire) head <= head + 1'b1;
      count <= count + {{IDX_W{1'b0}}, alloc_fire} - {{IDX_W{1'b0}}, commit_fire};
    end
  end

  assign full  = (count == ENTRIES[IDX_W:0]);
  assign empty = (count == '0);

endmodule

// File: rtl/rob_commit.sv
// 16-entry reorder buffer: in-order allocate, tagged writeback, in-order retire,
// and flush/redirect when a taken branch reaches the head (front end predicts not-taken).
module rob_commit import rob_commit_pkg::*; #(
  parameter int ENTRIES = ROB_ENTRIES,
  parameter int IDX_W   = ROB_IDX_W,
  parameter int DATA_W  = rob_commit_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  rob_commit_if.slave  bus
);

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] done_q;
  logic [ENTRIES-1:0] is_br_q;
  logic [ENTRIES-1:0] wr_q;
  logic [ENTRIES-1:0] taken_q;
  logic [REG_W-1:0]   dest_q  [ENTRIES];
  logic [DATA_W-1:0]  value_q [ENTRIES];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic             full;
  logic             empty;

  logic head_live;
  logic head_redirect;
  logic commit_fire;
  logic flush_fire;
  logic alloc_fire;
  logic alu_hit;
  logic br_hit;

  rob_commit_ptr #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_ptr (
    .clk         (clk),
    .reset       (reset),
    .alloc_fire  (alloc_fire),
    .commit_fire (commit_fire),
    .flush       (flush_fire),
    .head        (head),
    .tail        (tail),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  // Head decisions are combinational; the empty guard masks stale entry bits.
  always_comb begin
    head_live     = valid_q[head] && done_q[head] && !empty;
    head_redirect = is_br_q[head] && taken_q[head];
    commit_fire   = head_live && !head_redirect;
    flush_fire    = head_live && head_redirect;
    alloc_fire    = bus.alloc_valid && !full && !flush_fire;
    alu_hit       = bus.alu_valid && valid_q[bus.alu_index];
    br_hit        = bus.br_valid && valid_q[bus.br_index];
  end

  assign bus.alloc_ready  = !full && !flush_fire;
  assign bus.alloc_index  = tail;
  assign bus.commit_valid = commit_fire;
  assign bus.commit_wr    = commit_fire && wr_q[head] && !is_br_q[head];
  assign bus.commit_dest  = dest_q[head];
  assign bus.commit_value = value_q[head];
  assign bus.flush        = flush_fire;
  assign bus.flush_pc     = value_q[head];
  assign bus.count        = count;

  // Control state: a flush discards same-cycle allocation and writebacks.
  always_ff @(posedge clk) begin
    if (reset || flush_fire) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (commit_fire) valid_q[head] <= 1'b0;
      if (alloc_fire) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
      end
      if (alu_hit) done_q[bus.alu_index] <= 1'b1;
      if (br_hit)  done_q[bus.br_index]  <= 1'b1;
    end
  end

  // Payload is only meaningful while the matching valid/done bits are set.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      is_br_q[tail] <= bus.alloc_is_branch;
      wr_q[tail]    <= bus.alloc_wr;
      dest_q[tail]  <= bus.alloc_dest;
    end
    if (alu_hit) begin
      value_q[bus.alu_index] <= bus.alu_value;
      taken_q[bus.alu_index] <= 1'b0;
    end
    if (br_hit) begin
      value_q[bus.br_index] <= bus.br_target;
      taken_q[bus.br_index] <= bus.br_taken;
    end
  end

  a_wb_collision : assert property (@(posedge clk) disable iff (reset)
    !(bus.alu_valid && bus.br_valid && (bus.alu_index == bus.br_index)))
    else $error("alu and branch writeback target the same ROB index");

endmodule
